// File: rtl/cmvn_window.sv
// Sliding-window cepstral mean/variance normalisation over INFRAME frames of IDIM coefficients.
// Frames are normalised one at a time into a ring buffer. Each completed frame emits the whole window.

module cmvn_inv_sqrt #(
    parameter int VW = 44,
    parameter int RW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [VW-1:0] v,
    output logic          dv,
    output logic [RW-1:0] res
);
    localparam int TW = 2*RW + VW;
    localparam logic [TW-1:0] LIM = TW'(1) << 30;

    logic [VW-1:0] v_q;
    logic [RW-1:0] r, trial;
    logic [3:0]    bitpos;
    logic          busy;
    logic [TW-1:0] tprod;

    // Bitwise search for the largest r with r^2 * v <= 2^30, i.e. r = 1/sqrt(v) in Q.10.
    assign trial = r | (RW'(1) << bitpos);
    assign tprod = TW'(trial) * TW'(trial) * TW'(v_q);
    assign res   = r;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            r      <= '0;
            bitpos <= '0;
            busy   <= 1'b0;
            dv     <= 1'b0;
        end else begin
            dv <= 1'b0;
            if (start) begin
                v_q    <= v;
                r      <= '0;
                bitpos <= 4'(RW-1);
                busy   <= 1'b1;
            end else if (busy) begin
                if (tprod <= LIM) r <= trial;
                if (bitpos == 4'd0) begin
                    busy <= 1'b0;
                    dv   <= 1'b1;
                end else begin
                    bitpos <= bitpos - 4'd1;
                end
            end
        end
    end
endmodule

module cmvn_window #(
    parameter int IBIT    = 26,
    parameter int IFRAC   = 14,
    parameter int OBIT    = 13,
    parameter int IDIM    = 26,
    parameter int INFRAME = 5,
    parameter int DIVMUL  = (16384 + IDIM/2) / IDIM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   mode_var,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IBIT-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OBIT-1:0] out_data,
    output logic [5:0]             out_dim,
    output logic [2:0]             out_frame,
    output logic                   out_last
);
    localparam int SH = IFRAC - 10;
    localparam int XW = IBIT - SH;
    localparam int SW = XW + 6;
    localparam int MW = XW + 1;
    localparam int DW = XW + 2;
    localparam int QW = 2*DW - 4;
    localparam int RW = 12;   // wide enough to hold a scale of 2.0 exactly
    localparam int PW = DW + RW + 1;
    localparam int IW = $clog2(IDIM);
    localparam int FW = (INFRAME > 1) ? $clog2(INFRAME) : 1;
    localparam logic signed [15:0]   DM   = 16'(DIVMUL);
    localparam logic signed [PW-1:0] YMAX = PW'((64'sd1 <<< (OBIT-1)) - 64'sd1);
    localparam logic signed [PW-1:0] YMIN = ~YMAX;

    typedef enum logic [2:0] {LOAD, MEAN, SUB, SQR, VAR, ISR, SCALE, EMIT} state_t;
    state_t state, state_nx;

    logic signed [DW-1:0]   dbuf [IDIM];
    logic signed [OBIT-1:0] ring [INFRAME][IDIM];
    logic signed [SW-1:0]   sum;
    logic signed [MW-1:0]   mean;
    logic [QW-1:0]          sq, var_q;
    logic [RW-1:0]          scale, isr_res;
    logic                   mode_q, isr_busy, isr_start, isr_dv;
    logic [IW-1:0]          cnt, emit_d;
    logic [FW-1:0]          wptr, emit_f, rslot;
    logic [FW:0]            rsum;
    logic [2:0]             fill, fill_inc;

    logic signed [XW-1:0]     x_in;
    logic                     xfer, cnt_last, emit_end;
    logic signed [SW+15:0]    mprod;
    logic [QW+15:0]           vprod;
    logic signed [2*DW-1:0]   dsq;
    logic [2*DW-1:0]          dsq_u;
    logic [QW-1:0]            term;
    logic signed [PW-1:0]     yprod, ysh;
    logic signed [OBIT-1:0]   ysat;

    assign x_in     = XW'(in_data >>> SH);
    assign in_ready = (state == LOAD) && !rst && !clear;
    assign xfer     = in_valid && in_ready;
    assign cnt_last = (cnt == IW'(IDIM-1));
    assign fill_inc = (fill == 3'(INFRAME)) ? fill : fill + 3'd1;
    assign emit_end = (emit_f == FW'(INFRAME-1)) && (emit_d == IW'(IDIM-1));

    assign mprod = (SW+16)'(sum) * (SW+16)'(DM);
    assign vprod = (QW+16)'(sq) * (QW+16)'(DIVMUL);
    assign dsq   = (2*DW)'(dbuf[cnt]) * (2*DW)'(dbuf[cnt]);
    assign dsq_u = dsq;
    assign term  = QW'(dsq_u >> 10);

    always_comb begin
        yprod = PW'(dbuf[cnt]) * PW'($signed({1'b0, scale}));
        ysh   = yprod >>> 10;
        if (ysh > YMAX)      ysat = OBIT'(YMAX);
        else if (ysh < YMIN) ysat = OBIT'(YMIN);
        else                 ysat = OBIT'(ysh);
    end

    // Once the ring is full the write pointer sits on the oldest frame.
    assign rsum  = {1'b0, wptr} + {1'b0, emit_f};
    assign rslot = FW'((rsum >= (FW+1)'(INFRAME)) ? rsum - (FW+1)'(INFRAME) : rsum);

    assign out_valid = (state == EMIT) && !rst;
    assign out_data  = out_valid ? ring[rslot][emit_d] : '0;
    assign out_dim   = out_valid ? 6'(emit_d) : '0;
    assign out_frame = out_valid ? 3'(emit_f) : '0;
    assign out_last  = out_valid && emit_end;

    cmvn_inv_sqrt #(.VW(QW), .RW(RW)) u_isr (
        .clk   (clk),
        .rst   (rst || clear),
        .start (isr_start),
        .v     (var_q),
        .dv    (isr_dv),
        .res   (isr_res)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        isr_start = 1'b0;
        case (state)
            LOAD:  if (xfer && cnt_last) state_nx = MEAN;
            MEAN:  state_nx = SUB;
            SUB:   state_nx = mode_q ? SQR : SCALE;
            SQR:   if (cnt_last) state_nx = VAR;
            VAR:   state_nx = ISR;
            ISR: begin
                if (!isr_busy) begin
                    if (var_q == '0) state_nx = SCALE;
                    else             isr_start = 1'b1;
                end else if (isr_dv) begin
                    state_nx = SCALE;
                end
            end
            SCALE: if (cnt_last) state_nx = (fill_inc == 3'(INFRAME)) ? EMIT : LOAD;
            EMIT:  if (out_ready && emit_end) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
        if (clear) state_nx = LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum      <= '0;
            mean     <= '0;
            sq       <= '0;
            var_q    <= '0;
            scale    <= '0;
            mode_q   <= 1'b0;
            isr_busy <= 1'b0;
            cnt      <= '0;
            wptr     <= '0;
            fill     <= '0;
            emit_f   <= '0;
            emit_d   <= '0;
        end else begin
            case (state)
                LOAD: if (xfer) begin
                    sum <= sum + SW'(x_in);
                    if (cnt == '0) mode_q <= mode_var;
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                end
                MEAN: mean <= MW'(mprod >>> 14);
                SUB: begin
                    sum   <= '0;
                    sq    <= '0;
                    cnt   <= '0;
                    scale <= RW'(1024);
                end
                SQR: begin
                    sq  <= sq + term;
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                end
                VAR: var_q <= QW'(vprod >> 14);
                ISR: begin
                    if (!isr_busy) begin
                        if (var_q != '0) isr_busy <= 1'b1;
                    end else if (isr_dv) begin
                        scale    <= isr_res;
                        isr_busy <= 1'b0;
                    end
                end
                SCALE: begin
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last) begin
                        wptr <= (wptr == FW'(INFRAME-1)) ? '0 : wptr + 1'b1;
                        fill <= fill_inc;
                    end
                end
                EMIT: if (out_ready) begin
                    if (emit_d == IW'(IDIM-1)) begin
                        emit_d <= '0;
                        emit_f <= (emit_f == FW'(INFRAME-1)) ? '0 : emit_f + 1'b1;
                    end else begin
                        emit_d <= emit_d + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && xfer) dbuf[cnt] <= DW'(x_in);
        if (state == SUB)
            for (int i = 0; i < IDIM; i++) dbuf[i] <= dbuf[i] - DW'(mean);
        if (state == SCALE) ring[wptr][cnt] <= ysat;
    end
endmodule
